writeback_queue: RTL and testbench

- Result-writeback buffer directly upstream of the bank of 32-bit registers.
- Accepts ALU results (destination address plus data) through a valid/ready handshake and buffers them in FIFO order.
- Drains one entry per cycle into the register bank as a one-hot write-enable vector plus a shared data bus.
- Exports a per-register pending scoreboard so operand fetch can detect in-flight writes.

---
 rtl/wbq_pkg.sv | 27 ++
 rtl/writeback_queue_if.sv | 34 +++
 rtl/wbq_fifo.sv | 70 +++++++
 rtl/writeback_queue.sv | 83 ++++++++
 tb/tb_writeback_queue.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/wbq_pkg.sv
// Shared types for the writeback queue: entry layout, default widths and the
// register-select decode that treats index 0 and out-of-range indices as "no write".
package wbq_pkg;

   localparam int WBQ_DATA_W   = 32;
   localparam int WBQ_ADDR_W   = 5;
   localparam int WBQ_NUM_REGS = 32;
   localparam int WBQ_DEPTH    = 4;

   typedef struct packed {
      logic [WBQ_ADDR_W-1:0] addr;
      logic [WBQ_DATA_W-1:0] data;
   } wbq_entry_t;

   // Register 0 is hard-wired, so it never receives a write enable.
   function automatic logic [WBQ_NUM_REGS-1:0] onehot_decode(input logic [WBQ_ADDR_W-1:0] addr);
      logic [WBQ_NUM_REGS-1:0] oh;
      oh = '0;
      for (int i = 1; i < WBQ_NUM_REGS; i++) begin
         if (int'(addr) == i) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Result-push / register-drain bundle between the ALU, the writeback queue and the register bank.
// master = ALU and bank side, slave = the queue.
interface writeback_queue_if
   import wbq_pkg::*;
#(
   parameter int DATA_W   = WBQ_DATA_W,
   parameter int ADDR_W   = WBQ_ADDR_W,
   parameter int NUM_REGS = WBQ_NUM_REGS,
   parameter int DEPTH    = WBQ_DEPTH
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [ADDR_W-1:0]          in_addr;
   logic [DATA_W-1:0]          in_data;
   logic                       drain_en;
   logic [NUM_REGS-1:0]        wr_en;
   logic [DATA_W-1:0]          wr_data;
   logic [NUM_REGS-1:0]        pending;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       empty;

   modport master (
      output in_valid, in_addr, in_data, drain_en,
      input  in_ready, wr_en, wr_data, pending, count, full, empty
   );

   modport slave (
      input  in_valid, in_addr, in_data, drain_en,
      output in_ready, wr_en, wr_data, pending, count, full, empty
   );

endinterface

// File: rtl/wbq_fifo.sv
// Entry store with head/tail pointers, exact occupancy count and per-slot valid bits; 1-cycle write-to-head.
// Push is ignored when full and pop ignored when empty; the caller owns the handshake.
module wbq_fifo
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wbq_entry_t             push_ent,
   input  logic                   pop,
   output wbq_entry_t             head_ent,
   output wbq_entry_t [DEPTH-1:0] ents,
   output logic [DEPTH-1:0]       ent_vld,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty
);

   wbq_entry_t [DEPTH-1:0] mem;
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [DEPTH-1:0]       vld;
   logic                   push_ok;
   logic                   pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // head == tail only when empty or full, so push and pop never touch the same slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         vld   <= '0;
      end else begin
         if (push_ok) begin
            tail      <= tail + 1'b1;
            vld[tail] <= 1'b1;
         end
         if (pop_ok) begin
            head      <= head + 1'b1;
            vld[head] <= 1'b0;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

   // Payload needs no reset: every consumer qualifies it with vld or empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[tail] <= push_ent;
      end
   end

   assign head_ent = mem[head];
   assign ents     = mem;
   assign ent_vld  = vld;

endmodule

// File: rtl/writeback_queue.sv
// FIFO of ALU results draining one entry per cycle into the register bank; accept-to-write-enable is 1 cycle.
// in_ready drops when full or in reset, with no pass-through; drain_en low holds the queue.
module writeback_queue
   import wbq_pkg::*;
#(
   parameter int DATA_W   = WBQ_DATA_W,
   parameter int ADDR_W   = WBQ_ADDR_W,
   parameter int NUM_REGS = WBQ_NUM_REGS,
   parameter int DEPTH    = WBQ_DEPTH
) (
   input logic              clk,
   input logic              rst,
   writeback_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH+1);

   wbq_entry_t             in_ent;
   wbq_entry_t             head_ent;
   wbq_entry_t [DEPTH-1:0] ents;
   logic [DEPTH-1:0]       ent_vld;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic [ADDR_W-1:0]      head_addr;
   logic [DATA_W-1:0]      head_data;
   logic [NUM_REGS-1:0]    wr_en_c;
   logic [NUM_REGS-1:0]    pending_c;

   assign in_ent.addr = bus.in_addr;
   assign in_ent.data = bus.in_data;

   // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
   assign bus.in_ready = !full && !rst;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = bus.drain_en && !empty && !rst;

   wbq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_ent (in_ent),
      .pop      (pop),
      .head_ent (head_ent),
      .ents     (ents),
      .ent_vld  (ent_vld),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign head_addr = head_ent.addr;
   assign head_data = head_ent.data;

   always_comb begin
      wr_en_c = '0;
      if (pop) begin
         wr_en_c = onehot_decode(head_addr);
      end
   end

   // An entry still counts as pending in the cycle it is popped.
   always_comb begin
      pending_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) begin
            pending_c = pending_c | onehot_decode(ents[i].addr);
         end
      end
   end

   assign bus.wr_en   = wr_en_c;
   assign bus.wr_data = empty ? '0 : head_data;
   assign bus.pending = pending_c;
   assign bus.count   = count;
   assign bus.full    = full;
   assign bus.empty   = empty;

endmodule

// File: tb/tb_writeback_queue.sv
// Randomised and directed bench for writeback_queue: stimulus logs accepted results into a
// reference queue, a negedge monitor pops it against the drain port and a modelled register bank.
module tb_writeback_queue;

   localparam int DEPTH = 4;
   localparam int NREGS = 32;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   writeback_queue_if bus ();

   writeback_queue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   ent_t        model_q[$];
   logic [31:0] exp_regs [NREGS];
   logic [31:0] regs     [NREGS];

   // Register bank fed by the queue's write port.
   always @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (bus.wr_en[i]) regs[i] <= bus.wr_data;
      end
   end

   function automatic logic [31:0] ref_we(input logic [4:0] a);
      if (a != 5'd0 && int'(a) < NREGS) return 32'd1 << a;
      return 32'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Monitor: compares every cycle's outputs against the reference queue.
   int          m_size;
   logic [31:0] exp_pend;
   ent_t        m_e;

   always @(negedge clk) begin
      if (rst) begin
         model_q.delete();
         chk("rst_count",    bus.count,    0);
         chk("rst_empty",    bus.empty,    1);
         chk("rst_full",     bus.full,     0);
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_wr_en",    bus.wr_en,    0);
         chk("rst_pending",  bus.pending,  0);
      end else begin
         m_size   = model_q.size();
         exp_pend = 32'd0;
         foreach (model_q[i]) exp_pend |= ref_we(model_q[i].addr);
         chk("count",    bus.count,    m_size);
         chk("empty",    bus.empty,    m_size == 0);
         chk("full",     bus.full,     m_size == DEPTH);
         chk("in_ready", bus.in_ready, m_size < DEPTH);
         chk("pending",  bus.pending,  exp_pend);
         if (bus.drain_en && m_size > 0) begin
            m_e = model_q.pop_front();
            chk("wr_en",   bus.wr_en,   ref_we(m_e.addr));
            chk("wr_data", bus.wr_data, m_e.data);
            if (ref_we(m_e.addr) != 32'd0) exp_regs[m_e.addr] = m_e.data;
         end else begin
            chk("idle_wr_en",   bus.wr_en,   0);
            chk("idle_wr_data", bus.wr_data, (m_size > 0) ? model_q[0].data : 32'd0);
         end
      end
   end

   task automatic push_one(input logic [4:0] a, input logic [31:0] d);
      int   budget;
      logic ok;
      budget       = 200;
      ok           = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_data  = d;
      while (!ok && budget > 0) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         budget--;
      end
      bus.in_valid = 1'b0;
      if (ok) begin
         model_q.push_back('{addr: a, data: d});
      end else begin
         n_chk++;
         $display("FAIL push_timeout: addr %0d never accepted, want accepted", a);
      end
   endtask

   task automatic wait_drained();
      int budget;
      budget = 500;
      while (model_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      @(posedge clk);
      #1;
      if (budget == 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d entries left, want 0", model_q.size());
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREGS; i++) chk(tag, regs[i], exp_regs[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         regs[i]     = 32'd0;
         exp_regs[i] = 32'd0;
      end
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.drain_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single result, immediate drain.
      bus.drain_en = 1'b1;
      push_one(5'd3, 32'hDEADBEEF);
      wait_drained();
      chk("reg3_after_first", regs[3], 32'hDEADBEEF);

      // Fill with drain held, then release while a fifth result waits.
      bus.drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h100 + 32'(i));
      fork
         push_one(5'd6, 32'h600);
         begin
            repeat (3) @(posedge clk);
            #1 bus.drain_en = 1'b1;
         end
      join
      wait_drained();
      check_regs("reg_after_fill");

      // Same destination twice: last write wins.
      bus.drain_en = 1'b0;
      push_one(5'd5, 32'h1);
      push_one(5'd5, 32'h2);
      bus.drain_en = 1'b1;
      wait_drained();
      chk("reg5_last_wins", regs[5], 32'h2);

      // Register 0 entry is consumed without a write.
      push_one(5'd0, 32'hFFFF_FFFF);
      push_one(5'd31, 32'h3131);
      wait_drained();
      check_regs("reg_after_zero");

      // Steady push and pop at occupancy 2, wrapping the pointers.
      bus.drain_en = 1'b0;
      push_one(5'd10, 32'hA0);
      push_one(5'd11, 32'hA1);
      bus.drain_en = 1'b1;
      for (int i = 0; i < 10; i++) push_one(5'(12 + i), 32'hB0 + 32'(i));
      wait_drained();
      check_regs("reg_after_stream");

      // Reset with three entries queued and a write enable live.
      bus.drain_en = 1'b0;
      push_one(5'd7, 32'h7777);
      push_one(5'd8, 32'h8888);
      push_one(5'd9, 32'h9999);
      bus.drain_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_wr_en",   bus.wr_en,   0);
      chk("async_rst_pending", bus.pending, 0);
      chk("async_rst_count",   bus.count,   0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      check_regs("reg_after_reset");

      // Randomised traffic.
      for (int n = 0; n < 300; n++) begin
         bus.drain_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) push_one(5'($urandom_range(0, 31)), $urandom);
         else begin
            @(posedge clk);
            #1;
         end
      end
      bus.drain_en = 1'b1;
      wait_drained();
      check_regs("reg_after_random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
